datapath_seq_ctrl: RTL and testbench

Multi-cycle sequencer and arbiter in front of the CPU data path (register file + ALU).
- Two requesters share the one register-file write port:
  - an instruction port, which writes an ALU result using the IR format;
  - a load port, which writes external data straight into a register.
- Drives the data path's IR, data, write-enable and register-file-select inputs with correct setup/settle/write timing, so that no requester handles data-path timing.

---
 rtl/datapath_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_datapath_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq_ctrl.sv
// Write-port sequencer/arbiter for the register file + ALU: accept -> SETTLE_CYCLES settle -> one-cycle wEn.
// Readys are combinational and only asserted in IDLE; optional perf counters under `DPCTRL_PERF_EN`.
module datapath_seq_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             instValid,
  output logic             instReady,
  input  logic [WIDTH-1:0] instWord,
  input  logic             ldValid,
  output logic             ldReady,
  input  logic [4:0]       ldAddr,
  input  logic [WIDTH-1:0] ldData,
  output logic [WIDTH-1:0] irOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             wEn,
  output logic             registerFileSelect,
  output logic             busy,
  output logic             opDone,
  output logic             illegalOp
`ifdef DPCTRL_PERF_EN
  ,
  output logic [31:0]      instCount,
  output logic [31:0]      loadCount,
  output logic [31:0]      illegalCount
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, WRITE} state_e;

  localparam logic       PTR_INST = 1'b0;
  localparam logic       PTR_LD   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             rfsel_q, rfsel_d;
  logic             wen_q, wen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illop_q, illop_d;
  logic             inst_acc, ld_acc, op_legal;

  always_comb begin
    unique case (instWord[29:26])
      4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010,
      4'b1011, 4'b1100, 4'b1101, 4'b1110: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  // The pointer only breaks ties; a lone requester is always granted in IDLE.
  assign instReady = (state_q == IDLE) & instValid & (~ldValid | (ptr_q == PTR_INST));
  assign ldReady   = (state_q == IDLE) & ldValid & (~instValid | (ptr_q == PTR_LD));
  assign inst_acc  = instValid & instReady;
  assign ld_acc    = ldValid & ldReady;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_INST;
      ir_q    <= '0;
      dat_q   <= '0;
      rfsel_q <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      illop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ir_q    <= ir_d;
      dat_q   <= dat_d;
      rfsel_q <= rfsel_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      illop_q <= illop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (inst_acc || ld_acc) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
          ptr_d   = inst_acc ? PTR_LD : PTR_INST;
        end
      end
      SETTLE: begin
        // An illegal opcode spends a single SETTLE cycle flagged, then abandons the op.
        if (illop_q) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    ir_d    = ir_q;
    dat_d   = dat_q;
    rfsel_d = rfsel_q;
    illop_d = inst_acc & ~op_legal;
    wen_d   = (state_d == WRITE);
    done_d  = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
    if (inst_acc) begin
      ir_d    = instWord;
      rfsel_d = 1'b0;
    end else if (ld_acc) begin
      ir_d        = '0;
      ir_d[25:21] = ldAddr;
      dat_d       = ldData;
      rfsel_d     = 1'b1;
    end
  end

  assign irOut              = ir_q;
  assign dataOut            = dat_q;
  assign wEn                = wen_q;
  assign registerFileSelect = rfsel_q;
  assign busy               = busy_q;
  assign opDone             = done_q;
  assign illegalOp          = illop_q;

`ifdef DPCTRL_PERF_EN
  logic [31:0] inst_cnt_q, load_cnt_q, ill_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      inst_cnt_q <= '0;
      load_cnt_q <= '0;
      ill_cnt_q  <= '0;
    end else begin
      if (wen_q && !rfsel_q) inst_cnt_q <= inst_cnt_q + 32'd1;
      if (wen_q && rfsel_q)  load_cnt_q <= load_cnt_q + 32'd1;
      if (illop_q)           ill_cnt_q  <= ill_cnt_q + 32'd1;
    end
  end

  assign instCount    = inst_cnt_q;
  assign loadCount    = load_cnt_q;
  assign illegalCount = ill_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Bench for datapath_seq_ctrl: random and directed requests, scoreboard of expected write/illegal pulses.
module tb_datapath_seq_ctrl;
  localparam int W = 32;
  localparam int S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, instValid, ldValid;
  logic [W-1:0]  instWord, ldData;
  logic [4:0]    ldAddr;
  logic          instReady, ldReady, wEn, registerFileSelect, busy, opDone, illegalOp;
  logic [W-1:0]  irOut, dataOut;
`ifdef DPCTRL_PERF_EN
  logic [31:0]   instCount, loadCount, illegalCount;
`endif

  datapath_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rstN(rstN),
    .instValid(instValid), .instReady(instReady), .instWord(instWord),
    .ldValid(ldValid), .ldReady(ldReady), .ldAddr(ldAddr), .ldData(ldData),
    .irOut(irOut), .dataOut(dataOut), .wEn(wEn), .registerFileSelect(registerFileSelect),
    .busy(busy), .opDone(opDone), .illegalOp(illegalOp)
`ifdef DPCTRL_PERF_EN
    , .instCount(instCount), .loadCount(loadCount), .illegalCount(illegalCount)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_ld;
    bit          ill;
    int          due;
    logic [31:0] ir;
    logic [31:0] dat;
  } exp_t;
  exp_t sbq[$];

  // Reference model: a single op in flight, round-robin pointer, cycle at which IDLE resumes.
  bit          armed = 0;
  bit          m_ptr = 0;
  int          m_free = 0;
  logic [31:0] m_ir = '0, m_dat = '0;
  logic        m_rf = 1'b0;
  int          inst_acc_cnt = 0, ld_acc_cnt = 0;
  int          n_inst = 0, n_ld = 0, n_ill = 0;

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'h0, 4'h1, [4'h8:4'hE]};
  endfunction

  always @(negedge clk) begin : monitor
    bit   idle, ei, el;
    int   t;
    exp_t e;
    if (armed) begin
      idle = (cyc >= m_free);
      ei   = idle && instValid && (!ldValid || m_ptr == 0);
      el   = idle && ldValid && (!instValid || m_ptr == 1);
      chk("instReady", instReady, ei);
      chk("ldReady", ldReady, el);
      chk("busy", busy, !idle);
      chk("irOut", irOut, m_ir);
      chk("dataOut", dataOut, m_dat);
      chk("registerFileSelect", registerFileSelect, m_rf);
      chk("opDone_vs_wEn", opDone, wEn);

      if (wEn || illegalOp) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {wEn, illegalOp}, 2'b00);
        end else begin
          e = sbq.pop_front();
          chk("pulse_cycle", cyc, e.due);
          chk("illegalOp_kind", illegalOp, e.ill);
          chk("wEn_kind", wEn, !e.ill);
          chk("pulse_irOut", irOut, e.ir);
          chk("pulse_dataOut", dataOut, e.dat);
          chk("pulse_rfsel", registerFileSelect, e.is_ld);
          if (e.ill) n_ill++;
          else if (e.is_ld) n_ld++;
          else n_inst++;
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("missing_pulse", {wEn, illegalOp}, sbq[0].ill ? 2'b01 : 2'b10);
        void'(sbq.pop_front());
      end

      t = cyc + 1;  // edge at which any accept this cycle takes effect
      if (!rstN) begin
        m_ptr = 0; m_free = 0; m_ir = '0; m_dat = '0; m_rf = 1'b0;
        n_inst = 0; n_ld = 0; n_ill = 0;
        sbq.delete();
      end else if (ei) begin
        e.is_ld = 0;
        e.ill   = !legal_op(instWord[29:26]);
        e.due   = e.ill ? t : t + S;
        e.ir    = instWord;
        e.dat   = m_dat;
        m_ir    = instWord;
        m_rf    = 1'b0;
        m_free  = e.ill ? t + 1 : t + S + 1;
        m_ptr   = 1;
        sbq.push_back(e);
        inst_acc_cnt++;
      end else if (el) begin
        e.is_ld = 1;
        e.ill   = 0;
        e.due   = t + S;
        e.ir    = 32'(ldAddr) * 32'h0020_0000;
        e.dat   = ldData;
        m_ir    = e.ir;
        m_dat   = ldData;
        m_rf    = 1'b1;
        m_free  = t + S + 1;
        m_ptr   = 0;
        sbq.push_back(e);
        ld_acc_cnt++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge with valid dropped.
  task automatic send_inst(input logic [31:0] w);
    int c0;
    bit ok;
    c0 = inst_acc_cnt; ok = 0;
    instWord = w; instValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (inst_acc_cnt != c0) begin ok = 1; break; end
    end
    #1;
    instValid = 1'b0;
    instWord  = $urandom;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL inst_accept_timeout: no grant within 200 cycles");
    end
  endtask

  task automatic send_ld(input logic [4:0] a, input logic [31:0] d);
    int c0;
    bit ok;
    c0 = ld_acc_cnt; ok = 0;
    ldAddr = a; ldData = d; ldValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (ld_acc_cnt != c0) begin ok = 1; break; end
    end
    #1;
    ldValid = 1'b0;
    ldAddr  = 5'($urandom);
    ldData  = $urandom;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ld_accept_timeout: no grant within 200 cycles");
    end
  endtask

  initial begin
    rstN = 1'b0; instValid = 1'b0; ldValid = 1'b0;
    instWord = '0; ldData = '0; ldAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_irOut", irOut, 32'h0);
    chk("reset_dataOut", dataOut, 32'h0);
    chk("reset_wEn", wEn, 1'b0);
    chk("reset_rfsel", registerFileSelect, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_opDone", opDone, 1'b0);
    chk("reset_illegalOp", illegalOp, 1'b0);
    armed = 1;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    send_ld(5'd4, 32'h4);
    send_ld(5'd7, 32'h7);
    send_inst(32'h0164_3800);
    send_inst(32'h1C00_0000);  // opcode 0111
    send_inst(32'h47C4_FF00);
    repeat (3) @(posedge clk);
    #1;

    // Reset during SETTLE must suppress the write.
    send_ld(5'd9, 32'hDEAD_BEEF);
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    chk("abort_wEn", wEn, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_irOut", irOut, 32'h0);
    chk("abort_dataOut", dataOut, 32'h0);
    @(posedge clk); #1;

    // Simultaneous held requests: grants must alternate, instruction first.
    fork
      begin
        send_inst(32'h0000_0000 | 32'($urandom_range(0, 32'h03FF_FFFF)));
        send_inst(32'h2000_0000 | 32'($urandom_range(0, 32'h03FF_FFFF)));
      end
      begin
        send_ld(5'($urandom), $urandom);
        send_ld(5'($urandom), $urandom);
      end
    join

    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_inst($urandom);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_ld(5'($urandom), $urandom);
      end
    join

    repeat (S + 6) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
`ifdef DPCTRL_PERF_EN
    chk("instCount", instCount, n_inst);
    chk("loadCount", loadCount, n_ld);
    chk("illegalCount", illegalCount, n_ill);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
